tx_cic_ctrl: RTL and testbench
==============================

// Module: tx_cic_ctrl
// PURPOSE
//  Sequencer for the 2-channel TX CIC interpolator. Takes parallel I/Q pairs from the TX DSP,
//  serialises them into the interpolator's Avalon-ST input as 2-beat packets (I=SOP, Q=EOP),
//  and re-pairs the 14-bit interleaved output into DAC I/Q registers. Keeps the interpolator
//  fed under underflow by zero-stuffing, counts underflows, flags channel-order loss.
// PARAMETERS
//  IN_W        16  input sample width (I, Q, interpolator in_data)
//  OUT_W       14  interpolator output / DAC width
//  ZERO_STUFF  1   1: inject 0/0 pair on underflow; 0: idle the interpolator input instead
//  CNT_W       16  underflow counter width (saturating)
// PORTS
//  clk           in   1      system clock
//  reset_n       in   1      synchronous reset, active low
//  enable        in   1      TX run; drives cic_clken directly
//  iq_valid      in   1      I/Q pair available
//  iq_ready      out  1      pair accepted when iq_valid & iq_ready
//  i_data        in   IN_W   I sample
//  q_data        in   IN_W   Q sample
//  cic_in_valid  out  1      to interpolator in_valid
//  cic_in_ready  in   1      from interpolator in_ready
//  cic_in_data   out  IN_W   to in_data
//  cic_in_sop    out  1      high on I beat
//  cic_in_eop    out  1      high on Q beat
//  cic_in_error  out  2      constant 2'b00
//  cic_out_valid in   1      interpolator out_valid
//  cic_out_data  in   OUT_W  interpolator out_data
//  cic_out_chan  in   1      out_channel: 0=I, 1=Q
//  cic_out_ready out  1      constant 1 (DAC never backpressures)
//  cic_clken     out  1      = enable
//  dac_i, dac_q  out  OUT_W  paired output registers
//  dac_strobe    out  1      1-cycle pulse when dac_i/dac_q update together
//  underflow_cnt out  CNT_W  saturating underflow count
//  sync_err      out  1      sticky channel-order error
//  sync_clr      in   1      clears sync_err and underflow_cnt
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state IDLE; every output 0 except cic_out_ready=1; held pair,
//   hold_i and counters cleared. Reset mid-packet abandons it; no partial beat survives.
//  FSM IDLE / SEND_I / SEND_Q; cic_in_* are registered, valid only in SEND_I/SEND_Q.
//   iq_ready = enable & (IDLE | (SEND_Q & cic_in_ready)), combinational.
//   IDLE: pair accepted -> latch I/Q, SEND_I. Else if enable & ZERO_STUFF -> latch 0/0,
//    underflow_cnt++ (sat at all-ones), SEND_I. Else stay.
//   SEND_I: valid=1, data=I, sop=1, eop=0; advance to SEND_Q only when cic_in_ready=1.
//   SEND_Q: valid=1, data=Q, sop=0, eop=1; on cic_in_ready: accepted pair -> SEND_I (no bubble);
//    else enable & ZERO_STUFF -> stuff 0/0, count, SEND_I; else IDLE.
//  Data/sop/eop stable while valid & !ready (Avalon-ST hold rule).
//  enable falls mid-packet: the Q beat still completes; then IDLE. Never a lone SOP.
//  Output side, each cic_out_valid beat:
//   chan 0: hold_i<=data, have_i<=1; if have_i already 1 -> sync_err<=1 (newer I kept).
//   chan 1 & have_i: dac_i<=hold_i, dac_q<=data, dac_strobe=1 next cycle, have_i<=0.
//   chan 1 & !have_i: sync_err<=1, dac regs unchanged, no strobe.
//  sync_clr has priority over a same-cycle set/increment; clears both to 0.
//  Latency: pair accept -> I beat valid 1 cycle later; Q beat valid -> dac_strobe 1 cycle.
// STRUCTURE
//  Package tx_cic_pkg: IN_W/OUT_W defaults, state enum {IDLE,SEND_I,SEND_Q}, CHAN_I/CHAN_Q consts.
//  One sub-module: tx_cic_pair (output re-pairing, hold_i, sync_err); FSM stays in top.
// TESTING
//  1 enable=1, pairs (0x1234,0xABCD),(1,2) back-to-back, ready=1 -> beats 1234 sop,ABCD eop,1,2;
//    iq_ready high every 2nd cycle, no bubble.
//  2 ready low 3 cycles during SEND_I -> data 0x1234, sop held stable, then Q beat; no pair lost.
//  3 iq_valid=0 for 4 pairs, ZERO_STUFF=1 -> four 0/0 packets, underflow_cnt=4; ZERO_STUFF=0 ->
//    cic_in_valid=0, cnt=0.
//  4 output beats ch0=0x0100, ch1=0x3F00 -> dac_i=0x0100, dac_q=0x3F00, one strobe; then ch1,ch1
//    -> sync_err=1, dac unchanged; sync_clr -> sync_err=0, cnt=0.
//  5 enable drops during SEND_I -> Q beat still sent with eop, then IDLE, cic_clken=0.
//  6 reset_n low during SEND_Q with ready=0 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/tx_cic_pkg.sv
// Shared types and constants for the TX CIC interpolator sequencer.
// Holds default widths, the input-side FSM states and the output channel ids.
package tx_cic_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 14;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2
  } state_t;

  localparam logic CHAN_I = 1'b0;
  localparam logic CHAN_Q = 1'b1;

endpackage

// File: rtl/tx_cic_pair.sv
// Re-pairs the interleaved interpolator output into DAC I/Q registers and
// raises a sticky error whenever the I/Q channel order is broken.
module tx_cic_pair
  import tx_cic_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  input  logic signed [OUT_W-1:0] i_data,
  input  logic                    i_chan,
  input  logic                    i_clr,
  output logic signed [OUT_W-1:0] o_dac_i,
  output logic signed [OUT_W-1:0] o_dac_q,
  output logic                    o_strobe,
  output logic                    o_sync_err
);

  logic signed [OUT_W-1:0] r_hold_i;
  logic                    r_have_i;
  logic signed [OUT_W-1:0] r_dac_i;
  logic signed [OUT_W-1:0] r_dac_q;
  logic                    r_strobe;
  logic                    r_sync_err;

  logic w_beat_i;
  logic w_beat_q;
  logic w_pair;
  logic w_err;

  assign w_beat_i = i_valid & (i_chan == CHAN_I);
  assign w_beat_q = i_valid & (i_chan == CHAN_Q);
  assign w_pair   = w_beat_q & r_have_i;
  // A second I before its Q, or a Q with no I waiting, both mean lost order.
  assign w_err    = (w_beat_i & r_have_i) | (w_beat_q & ~r_have_i);

  // Stage boundary: beat in -> paired DAC registers and strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_i   <= '0;
      r_have_i   <= 1'b0;
      r_dac_i    <= '0;
      r_dac_q    <= '0;
      r_strobe   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_strobe <= w_pair;
      if (w_beat_i) begin
        r_hold_i <= i_data;
        r_have_i <= 1'b1;
      end else if (w_pair) begin
        r_dac_i  <= r_hold_i;
        r_dac_q  <= i_data;
        r_have_i <= 1'b0;
      end
      if (i_clr) begin
        r_sync_err <= 1'b0;
      end else if (w_err) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign o_dac_i    = r_dac_i;
  assign o_dac_q    = r_dac_q;
  assign o_strobe   = r_strobe;
  assign o_sync_err = r_sync_err;

endmodule

// File: rtl/tx_cic_ctrl.sv
// Sequencer for the 2-channel TX CIC interpolator: serialises I/Q pairs into
// 2-beat Avalon-ST packets, zero-stuffs on underflow and re-pairs the output.
module tx_cic_ctrl
  import tx_cic_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter bit ZERO_STUFF = 1'b1,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    iq_valid,
  output logic                    iq_ready,
  input  logic signed [IN_W-1:0]  i_data,
  input  logic signed [IN_W-1:0]  q_data,
  output logic                    cic_in_valid,
  input  logic                    cic_in_ready,
  output logic signed [IN_W-1:0]  cic_in_data,
  output logic                    cic_in_sop,
  output logic                    cic_in_eop,
  output logic [1:0]              cic_in_error,
  input  logic                    cic_out_valid,
  input  logic signed [OUT_W-1:0] cic_out_data,
  input  logic                    cic_out_chan,
  output logic                    cic_out_ready,
  output logic                    cic_clken,
  output logic signed [OUT_W-1:0] dac_i,
  output logic signed [OUT_W-1:0] dac_q,
  output logic                    dac_strobe,
  output logic [CNT_W-1:0]        underflow_cnt,
  output logic                    sync_err,
  input  logic                    sync_clr
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  logic signed [IN_W-1:0] r_pair_i;
  logic signed [IN_W-1:0] r_pair_q;
  logic signed [IN_W-1:0] w_pair_i_nxt;
  logic signed [IN_W-1:0] w_pair_q_nxt;

  logic                   r_in_valid;
  logic signed [IN_W-1:0] r_in_data;
  logic                   r_in_sop;
  logic                   r_in_eop;
  logic [CNT_W-1:0]       r_ucnt;

  logic w_slot;
  logic w_stuff;

  // A new packet may start when idle or as the Q beat is being taken.
  assign w_slot   = (r_state == IDLE) | ((r_state == SEND_Q) & cic_in_ready);
  assign iq_ready = enable & w_slot;

  always_comb begin
    w_state_nxt  = r_state;
    w_pair_i_nxt = r_pair_i;
    w_pair_q_nxt = r_pair_q;
    w_stuff      = 1'b0;
    case (r_state)
      SEND_I: begin
        if (cic_in_ready) w_state_nxt = SEND_Q;
      end
      IDLE, SEND_Q: begin
        if (w_slot) begin
          if (iq_valid && iq_ready) begin
            w_pair_i_nxt = i_data;
            w_pair_q_nxt = q_data;
            w_state_nxt  = SEND_I;
          end else if (enable && ZERO_STUFF) begin
            w_pair_i_nxt = '0;
            w_pair_q_nxt = '0;
            w_stuff      = 1'b1;
            w_state_nxt  = SEND_I;
          end else begin
            w_state_nxt  = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage boundary: FSM decision -> registered Avalon-ST beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pair_i   <= '0;
      r_pair_q   <= '0;
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
      r_in_sop   <= 1'b0;
      r_in_eop   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pair_i   <= w_pair_i_nxt;
      r_pair_q   <= w_pair_q_nxt;
      r_in_valid <= (w_state_nxt != IDLE);
      r_in_sop   <= (w_state_nxt == SEND_I);
      r_in_eop   <= (w_state_nxt == SEND_Q);
      if (w_state_nxt == SEND_I) begin
        r_in_data <= w_pair_i_nxt;
      end else if (w_state_nxt == SEND_Q) begin
        r_in_data <= w_pair_q_nxt;
      end else begin
        r_in_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ucnt <= '0;
    end else if (sync_clr) begin
      r_ucnt <= '0;
    end else if (w_stuff) begin
      r_ucnt <= sat_inc(r_ucnt);
    end
  end

  tx_cic_pair #(
    .OUT_W(OUT_W)
  ) u_pair (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   (cic_out_valid),
    .i_data    (cic_out_data),
    .i_chan    (cic_out_chan),
    .i_clr     (sync_clr),
    .o_dac_i   (dac_i),
    .o_dac_q   (dac_q),
    .o_strobe  (dac_strobe),
    .o_sync_err(sync_err)
  );

  assign cic_in_valid  = r_in_valid;
  assign cic_in_data   = r_in_data;
  assign cic_in_sop    = r_in_sop;
  assign cic_in_eop    = r_in_eop;
  assign cic_in_error  = 2'b00;
  assign cic_out_ready = 1'b1;
  assign cic_clken     = enable;
  assign underflow_cnt = r_ucnt;

endmodule

// File: tb/tb_tx_cic_ctrl.sv
// Randomised and directed bench for tx_cic_ctrl: one zero-stuffing instance with a
// narrow counter and one idling instance, both checked against a packet-level model.
module tb_tx_cic_ctrl;

  localparam int IN_W  = 16;
  localparam int OUT_W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, enable, iq_valid, cic_in_ready;
  logic             cic_out_valid, cic_out_chan, sync_clr;
  logic [IN_W-1:0]  i_data, q_data;
  logic [OUT_W-1:0] cic_out_data;

  logic             iq_rdy [2];
  logic             in_vld [2];
  logic             in_sop [2];
  logic             in_eop [2];
  logic [IN_W-1:0]  in_data[2];
  logic [1:0]       in_err [2];
  logic             out_rdy[2];
  logic             clken  [2];
  logic [OUT_W-1:0] dac_i  [2];
  logic [OUT_W-1:0] dac_q  [2];
  logic             stb    [2];
  logic             serr   [2];
  logic [2:0]       cnt_zs;
  logic [15:0]      cnt_nz;

  int checks   = 0;
  int failures = 0;

  tx_cic_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .ZERO_STUFF(1'b1), .CNT_W(3)) u_zs (
    .clk(clk), .reset_n(reset_n), .enable(enable), .iq_valid(iq_valid),
    .iq_ready(iq_rdy[0]), .i_data(i_data), .q_data(q_data),
    .cic_in_valid(in_vld[0]), .cic_in_ready(cic_in_ready), .cic_in_data(in_data[0]),
    .cic_in_sop(in_sop[0]), .cic_in_eop(in_eop[0]), .cic_in_error(in_err[0]),
    .cic_out_valid(cic_out_valid), .cic_out_data(cic_out_data), .cic_out_chan(cic_out_chan),
    .cic_out_ready(out_rdy[0]), .cic_clken(clken[0]), .dac_i(dac_i[0]), .dac_q(dac_q[0]),
    .dac_strobe(stb[0]), .underflow_cnt(cnt_zs), .sync_err(serr[0]), .sync_clr(sync_clr)
  );

  tx_cic_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .ZERO_STUFF(1'b0), .CNT_W(16)) u_nz (
    .clk(clk), .reset_n(reset_n), .enable(enable), .iq_valid(iq_valid),
    .iq_ready(iq_rdy[1]), .i_data(i_data), .q_data(q_data),
    .cic_in_valid(in_vld[1]), .cic_in_ready(cic_in_ready), .cic_in_data(in_data[1]),
    .cic_in_sop(in_sop[1]), .cic_in_eop(in_eop[1]), .cic_in_error(in_err[1]),
    .cic_out_valid(cic_out_valid), .cic_out_data(cic_out_data), .cic_out_chan(cic_out_chan),
    .cic_out_ready(out_rdy[1]), .cic_clken(clken[1]), .dac_i(dac_i[1]), .dac_q(dac_q[1]),
    .dac_strobe(stb[1]), .underflow_cnt(cnt_nz), .sync_err(serr[1]), .sync_clr(sync_clr)
  );

  // Packet-level model: m_n = beats of the current packet still owed to the interpolator.
  int              m_n   [2];
  logic [IN_W-1:0] m_i   [2];
  logic [IN_W-1:0] m_q   [2];
  int              m_cnt [2];
  int              m_cmax[2];
  bit              m_zs  [2];
  bit              m_acc;
  logic             m_have, m_stb, m_err;
  logic [OUT_W-1:0] m_hold, m_di, m_dq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    return (d == 0) ? {29'd0, cnt_zs} : {16'd0, cnt_nz};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0; m_i[d] = '0; m_q[d] = '0; m_cnt[d] = 0;
    end
    m_have = 0; m_stb = 0; m_err = 0; m_hold = '0; m_di = '0; m_dq = '0;
    m_acc = 0;
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      string p;
      logic [IN_W-1:0] ed;
      logic eready;
      p = (d == 0) ? "zs." : "nz.";
      ed = (m_n[d] == 2) ? m_i[d] : (m_n[d] == 1) ? m_q[d] : '0;
      eready = enable && (m_n[d] == 0 || (m_n[d] == 1 && cic_in_ready));
      check({p, "in_valid"}, 32'(in_vld[d]), 32'(m_n[d] != 0));
      check({p, "in_data"},  32'(in_data[d]), 32'(ed));
      check({p, "in_sop"},   32'(in_sop[d]), 32'(m_n[d] == 2));
      check({p, "in_eop"},   32'(in_eop[d]), 32'(m_n[d] == 1));
      check({p, "iq_ready"}, 32'(iq_rdy[d]), 32'(eready));
      check({p, "in_error"}, 32'(in_err[d]), 32'd0);
      check({p, "out_ready"}, 32'(out_rdy[d]), 32'd1);
      check({p, "clken"},    32'(clken[d]), 32'(enable));
      check({p, "ucnt"},     cnt_of(d), 32'(m_cnt[d]));
      check({p, "dac_i"},    32'(dac_i[d]), 32'(m_di));
      check({p, "dac_q"},    32'(dac_q[d]), 32'(m_dq));
      check({p, "strobe"},   32'(stb[d]), 32'(m_stb));
      check({p, "sync_err"}, 32'(serr[d]), 32'(m_err));
    end
  endtask

  task automatic model_update();
    bit seterr;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_acc = 0;
    for (int d = 0; d < 2; d++) begin
      bit pop, stuff;
      pop = (m_n[d] != 0) && cic_in_ready;
      stuff = 0;
      if (pop) m_n[d] = m_n[d] - 1;
      if (m_n[d] == 0 && ((m_n[d] == 0 && !pop && enable) || pop)) begin
        if (enable && iq_valid) begin
          m_i[d] = i_data; m_q[d] = q_data; m_n[d] = 2;
          if (d == 0) m_acc = 1;
        end else if (enable && m_zs[d]) begin
          m_i[d] = '0; m_q[d] = '0; m_n[d] = 2; stuff = 1;
        end
      end
      if (sync_clr) m_cnt[d] = 0;
      else if (stuff && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
    end
    m_stb = 0;
    seterr = 0;
    if (cic_out_valid) begin
      if (cic_out_chan == 1'b0) begin
        if (m_have) seterr = 1;
        m_hold = cic_out_data; m_have = 1;
      end else if (m_have) begin
        m_di = m_hold; m_dq = cic_out_data; m_stb = 1; m_have = 0;
      end else begin
        seterr = 1;
      end
    end
    if (sync_clr) m_err = 0;
    else if (seterr) m_err = 1;
  endtask

  // Inputs are set by the caller just after a rising edge; after tick() returns the
  // DUT shows the state produced by those inputs.
  task automatic tick();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset_n = 1; enable = 0; iq_valid = 0; i_data = '0; q_data = '0;
    cic_in_ready = 1; cic_out_valid = 0; cic_out_chan = 0; cic_out_data = '0; sync_clr = 0;
  endtask

  logic [IN_W-1:0] pairs_i[3];
  logic [IN_W-1:0] pairs_q[3];

  initial begin
    int k;
    m_cmax[0] = 7;  m_cmax[1] = 65535;
    m_zs[0]   = 1;  m_zs[1]   = 0;
    pairs_i[0] = 16'h1234; pairs_q[0] = 16'hABCD;
    pairs_i[1] = 16'h0001; pairs_q[1] = 16'h0002;
    pairs_i[2] = 16'h8000; pairs_q[2] = 16'h7FFF;
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset_n = 1;

    // Back-to-back pairs with a always-ready interpolator
    k = 0;
    enable = 1;
    for (int n = 0; n < 12 && k < 3; n++) begin
      iq_valid = 1; i_data = pairs_i[k]; q_data = pairs_q[k];
      tick();
      if (m_acc) k++;
    end
    check("t1.pairs_taken", 32'(k), 32'd3);
    iq_valid = 0; enable = 0;
    repeat (3) tick();

    // Interpolator stalls on the I beat
    enable = 1; iq_valid = 1; i_data = 16'h1234; q_data = 16'hABCD; cic_in_ready = 1;
    tick();
    iq_valid = 0; enable = 0; cic_in_ready = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("t2.hold_valid", 32'(in_vld[0]), 32'd1);
      check("t2.hold_data", 32'(in_data[0]), 32'h1234);
      check("t2.hold_sop", 32'(in_sop[0]), 32'd1);
    end
    cic_in_ready = 1;
    tick();
    check("t2.q_data", 32'(in_data[0]), 32'hABCD);
    check("t2.q_eop", 32'(in_eop[0]), 32'd1);
    repeat (3) tick();

    // Underflow: stuffing instance counts, idling instance stays silent
    sync_clr = 1;
    tick();
    sync_clr = 0; enable = 1; iq_valid = 0;
    repeat (8) tick();
    check("t3.cnt_zs", cnt_of(0), 32'd4);
    check("t3.cnt_nz", cnt_of(1), 32'd0);
    check("t3.nz_idle", 32'(in_vld[1]), 32'd0);
    enable = 0;
    repeat (3) tick();

    // Output re-pairing and order errors
    cic_out_valid = 1; cic_out_chan = 0; cic_out_data = 14'h0100;
    tick();
    cic_out_chan = 1; cic_out_data = 14'h3F00;
    tick();
    check("t4.dac_i", 32'(dac_i[0]), 32'h0100);
    check("t4.dac_q", 32'(dac_q[0]), 32'h3F00);
    check("t4.strobe", 32'(stb[0]), 32'd1);
    cic_out_valid = 0;
    tick();
    check("t4.strobe_once", 32'(stb[0]), 32'd0);
    cic_out_valid = 1; cic_out_chan = 1; cic_out_data = 14'h1111;
    tick();
    cic_out_data = 14'h2222;
    tick();
    cic_out_valid = 0;
    check("t4.sync_err", 32'(serr[1]), 32'd1);
    check("t4.dac_i_kept", 32'(dac_i[1]), 32'h0100);
    check("t4.dac_q_kept", 32'(dac_q[1]), 32'h3F00);
    sync_clr = 1;
    tick();
    sync_clr = 0;
    check("t4.err_clr", 32'(serr[0]), 32'd0);
    check("t4.cnt_clr", cnt_of(0), 32'd0);

    // Enable falls while the I beat is stalled
    enable = 1; iq_valid = 1; i_data = 16'h5A5A; q_data = 16'hA5A5; cic_in_ready = 1;
    tick();
    enable = 0; iq_valid = 0; cic_in_ready = 0;
    tick();
    check("t5.clken", 32'(clken[0]), 32'd0);
    check("t5.sop_held", 32'(in_sop[0]), 32'd1);
    cic_in_ready = 1;
    tick();
    check("t5.q_eop", 32'(in_eop[0]), 32'd1);
    check("t5.q_data", 32'(in_data[0]), 32'hA5A5);
    tick();
    check("t5.idle", 32'(in_vld[0]), 32'd0);

    // Reset while the Q beat is stalled
    enable = 1; iq_valid = 1; i_data = 16'h0F0F; q_data = 16'hF0F0; cic_in_ready = 1;
    tick();
    iq_valid = 0; enable = 0;
    tick();
    cic_in_ready = 0;
    tick();
    check("t6.q_stalled", 32'(in_eop[0]), 32'd1);
    reset_n = 0;
    tick();
    reset_n = 1;
    check("t6.valid", 32'(in_vld[0]), 32'd0);
    check("t6.data", 32'(in_data[0]), 32'd0);
    check("t6.sop", 32'(in_sop[0]), 32'd0);
    check("t6.eop", 32'(in_eop[0]), 32'd0);
    check("t6.iq_ready", 32'(iq_rdy[0]), 32'd0);
    check("t6.out_ready", 32'(out_rdy[0]), 32'd1);
    tick();

    // Random traffic on both sides with occasional clears and resets
    for (int n = 0; n < 4000; n++) begin
      reset_n       = ($urandom_range(0, 299) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      iq_valid      = ($urandom_range(0, 3) != 0);
      i_data        = 16'($urandom);
      q_data        = 16'($urandom);
      cic_in_ready  = ($urandom_range(0, 2) != 0);
      cic_out_valid = $urandom_range(0, 1) == 1;
      cic_out_chan  = (n % 2 == 1) ^ ($urandom_range(0, 9) == 0);
      cic_out_data  = 14'($urandom);
      sync_clr      = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
